// File: rtl/izhikevich_pkg.sv
// Shared definitions for the time-multiplexed Izhikevich neuron bank.
//   - state_t         : sweep controller states
//   - FX_N / FX_Q     : fixed-point word width and fractional bits
//   - K_004/K_5/K_140 : model constants 0.04, 5 and 140 in FX_Q format
//   - fx_mul/fx_add/fx_sub : fixed-point arithmetic helpers
// Optional build macro IZH_SATURATE_EN: when defined every add/subtract and
// every product truncation saturates on signed overflow; otherwise results
// wrap modulo 2^FX_N.
package izhikevich_pkg;

  localparam int FX_N = 32;
  localparam int FX_Q = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    UPDATE,
    DONE
  } state_t;

  localparam logic signed [FX_N-1:0] K_004 = FX_N'((2 ** FX_Q * 4 + 50) / 100);
  localparam logic signed [FX_N-1:0] K_5   = FX_N'(5 << FX_Q);
  localparam logic signed [FX_N-1:0] K_140 = FX_N'(140 << FX_Q);

`ifdef IZH_SATURATE_EN
  localparam logic signed [FX_N-1:0] FX_MAX = {1'b0, {(FX_N-1){1'b1}}};
  localparam logic signed [FX_N-1:0] FX_MIN = {1'b1, {(FX_N-1){1'b0}}};
`endif

  // Full-width product, arithmetic shift right by FX_Q, keep FX_N bits.
  // Dropping the low bits of a two's complement value rounds toward -inf.
  function automatic logic signed [FX_N-1:0] fx_mul(input logic signed [FX_N-1:0] x,
                                                    input logic signed [FX_N-1:0] y);
    logic signed [2*FX_N-1:0] p;
    p = x * y;
`ifdef IZH_SATURATE_EN
    // Every bit above the kept sign bit must be a copy of the product sign.
    if (p[2*FX_N-1:FX_N+FX_Q-1] != {(FX_N-FX_Q+1){p[2*FX_N-1]}})
      return p[2*FX_N-1] ? FX_MIN : FX_MAX;
`endif
    return p[FX_Q +: FX_N];
  endfunction

  function automatic logic signed [FX_N-1:0] fx_add(input logic signed [FX_N-1:0] x,
                                                    input logic signed [FX_N-1:0] y);
    logic signed [FX_N-1:0] s;
    s = x + y;
`ifdef IZH_SATURATE_EN
    if ((x[FX_N-1] == y[FX_N-1]) && (s[FX_N-1] != x[FX_N-1]))
      return x[FX_N-1] ? FX_MIN : FX_MAX;
`endif
    return s;
  endfunction

  function automatic logic signed [FX_N-1:0] fx_sub(input logic signed [FX_N-1:0] x,
                                                    input logic signed [FX_N-1:0] y);
    logic signed [FX_N-1:0] s;
    s = x - y;
`ifdef IZH_SATURATE_EN
    if ((x[FX_N-1] != y[FX_N-1]) && (s[FX_N-1] != x[FX_N-1]))
      return x[FX_N-1] ? FX_MIN : FX_MAX;
`endif
    return s;
  endfunction

endpackage

// File: rtl/izhikevich_if.sv
// Control/parameter/readback bundle of the Izhikevich neuron bank.
//   slave  : seen by the bank (parameters, current writes, step and rd_addr
//            in; busy, done, spikes, rd_voltage, rd_w out)
//   master : seen by the surrounding logic (directions reversed)
interface izhikevich_if #(
  parameter int N           = 32,
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
);
  logic signed [N-1:0]      v_init;
  logic signed [N-1:0]      w_init;
  logic signed [N-1:0]      a;
  logic signed [N-1:0]      b;
  logic signed [N-1:0]      c;
  logic signed [N-1:0]      d;
  logic signed [N-1:0]      v_th;
  logic signed [N-1:0]      dt;
  logic                     cur_wr_en;
  logic [ADDR_W-1:0]        cur_wr_addr;
  logic signed [N-1:0]      cur_wr_data;
  logic                     step;
  logic                     busy;
  logic                     done;
  logic [NUM_NEURONS-1:0]   spikes;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [N-1:0]      rd_voltage;
  logic signed [N-1:0]      rd_w;

  modport master (
    output v_init, w_init, a, b, c, d, v_th, dt,
    output cur_wr_en, cur_wr_addr, cur_wr_data, step, rd_addr,
    input  busy, done, spikes, rd_voltage, rd_w
  );

  modport slave (
    input  v_init, w_init, a, b, c, d, v_th, dt,
    input  cur_wr_en, cur_wr_addr, cur_wr_data, step, rd_addr,
    output busy, done, spikes, rd_voltage, rd_w
  );
endinterface

// File: rtl/izhikevich_update.sv
// Shared Izhikevich update datapath: one registered multiply stage followed
// by the combinational Euler update.
//   clk, reset      : clock, synchronous active-high reset (valid flag only)
//   vld_p0          : v_p0/w_p0/i_p0 hold a fetched neuron this cycle
//   v_p0,w_p0,i_p0  : fetched voltage, recovery and input current
//   a,b,c,d,v_th,dt : model parameters
//   vld_p1          : v_next/w_next/spike are valid this cycle
//   v_next,w_next   : new state to write back (already reset on spike)
//   spike           : v' >= v_th
// Honours IZH_SATURATE_EN through the package arithmetic helpers.
module izhikevich_update
  import izhikevich_pkg::*;
#(
  parameter int N = FX_N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vld_p0,
  input  logic signed [N-1:0] v_p0,
  input  logic signed [N-1:0] w_p0,
  input  logic signed [N-1:0] i_p0,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  input  logic signed [N-1:0] v_th,
  input  logic signed [N-1:0] dt,
  output logic                vld_p1,
  output logic signed [N-1:0] v_next,
  output logic signed [N-1:0] w_next,
  output logic                spike
);

  logic signed [N-1:0] v_p1, w_p1, i_p1;
  logic signed [N-1:0] v2k_p1, v5_p1, bv_p1;
  logic signed [N-1:0] dv, dw, v_new, w_new;

  // ---- stage p0 -> p1 : products ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      v_p1   <= v_p0;
      w_p1   <= w_p0;
      i_p1   <= i_p0;
      v2k_p1 <= fx_mul(K_004, fx_mul(v_p0, v_p0));
      v5_p1  <= fx_mul(K_5, v_p0);
      bv_p1  <= fx_mul(b, v_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  // ---- stage p1 : Euler update and spike decision ----
  always_comb begin
    dv     = fx_add(fx_sub(fx_add(fx_add(v2k_p1, v5_p1), K_140), w_p1), i_p1);
    dw     = fx_mul(a, fx_sub(bv_p1, w_p1));
    v_new  = fx_add(v_p1, fx_mul(dv, dt));
    w_new  = fx_add(w_p1, fx_mul(dw, dt));
    spike  = (v_new >= v_th);
    v_next = spike ? c : v_new;
    w_next = spike ? fx_add(w_new, d) : w_new;
  end

endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed bank of NUM_NEURONS Izhikevich neurons. Each step pulse
// sweeps every neuron through FETCH -> MUL -> UPDATE on one shared datapath
// and publishes the spike vector with a one-cycle done pulse.
//   clk, reset : clock, synchronous active-high reset (reloads v/w from
//                v_init/w_init, clears currents, aborts any sweep)
//   bus        : izhikevich_if.slave -- parameters, current write port,
//                step/busy/done/spikes, registered readback rd_voltage/rd_w
// N and Q must equal the package FX_N/FX_Q (the arithmetic helpers are fixed
// to that format). Optional macro IZH_SATURATE_EN selects saturating
// arithmetic instead of wrap-around.
module izhikevich_array
  import izhikevich_pkg::*;
#(
  parameter int N           = FX_N,
  parameter int Q           = FX_Q,
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic       clk,
  input  logic       reset,
  izhikevich_if.slave bus
);

  if (N != FX_N || Q != FX_Q) begin : g_cfg_check
    $error("izhikevich_array: N and Q must equal izhikevich_pkg FX_N and FX_Q");
  end

  localparam logic [ADDR_W:0]   NUM_L    = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_t                 state;
  logic [ADDR_W-1:0]      idx;
  logic signed [N-1:0]    v_mem   [NUM_NEURONS];
  logic signed [N-1:0]    w_mem   [NUM_NEURONS];
  logic signed [N-1:0]    cur_mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spike_next;
  logic [NUM_NEURONS-1:0] spike_vec;

  logic signed [N-1:0]    v_p0, w_p0, i_p0;
  logic                   vld_p0;
  logic                   vld_p1;
  logic signed [N-1:0]    v_next, w_next;
  logic                   spike;
  logic                   wr_ok;
  logic                   rd_ok;

  assign wr_ok  = bus.cur_wr_en && ({1'b0, bus.cur_wr_addr} < NUM_L);
  assign rd_ok  = ({1'b0, bus.rd_addr} < NUM_L);
  assign vld_p0 = (state == MUL);

  // ---- stage p0 : fetch neuron idx ----
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      v_p0 <= v_mem[idx];
      w_p0 <= w_mem[idx];
      i_p0 <= cur_mem[idx];
    end
  end

  izhikevich_update #(.N(N)) u_update (
    .clk    (clk),
    .reset  (reset),
    .vld_p0 (vld_p0),
    .v_p0   (v_p0),
    .w_p0   (w_p0),
    .i_p0   (i_p0),
    .a      (bus.a),
    .b      (bus.b),
    .c      (bus.c),
    .d      (bus.d),
    .v_th   (bus.v_th),
    .dt     (bus.dt),
    .vld_p1 (vld_p1),
    .v_next (v_next),
    .w_next (w_next),
    .spike  (spike)
  );

  // The last neuron's flag is still in flight when spikes is loaded, so
  // merge it in directly.
  always_comb begin
    spike_vec      = spike_next;
    spike_vec[idx] = spike;
  end

  // ---- stage p1 : write-back, sequencing, readback ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.spikes     <= '0;
      bus.rd_voltage <= '0;
      bus.rd_w       <= '0;
      spike_next     <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k]   <= bus.v_init;
        w_mem[k]   <= bus.w_init;
        cur_mem[k] <= '0;
      end
    end else begin
      bus.done       <= 1'b0;
      // Non-blocking reads give the pre-update value on a same-cycle write.
      bus.rd_voltage <= rd_ok ? v_mem[bus.rd_addr] : '0;
      bus.rd_w       <= rd_ok ? w_mem[bus.rd_addr] : '0;

      // A write to the neuron being fetched lands after the fetch samples it.
      if (wr_ok) cur_mem[bus.cur_wr_addr] <= bus.cur_wr_data;

      if (vld_p1) begin
        v_mem[idx]      <= v_next;
        w_mem[idx]      <= w_next;
        spike_next[idx] <= spike;
      end

      case (state)
        IDLE: begin
          if (bus.step) begin
            state    <= FETCH;
            idx      <= '0;
            bus.busy <= 1'b1;
          end
        end
        FETCH:  state <= MUL;
        MUL:    state <= UPDATE;
        UPDATE: begin
          if (idx == LAST_IDX) begin
            state      <= DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.spikes <= spike_vec;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_array.sv
module tb_izhikevich_array;

  localparam int NN   = 8;
  localparam int AW   = 3;
  localparam int QS   = 16;
  localparam int ONE  = 1 << QS;
  localparam int PA   = 1311;      // 0.02
  localparam int PB   = 13107;     // 0.2
  localparam int PC   = -65 * ONE;
  localparam int PD   = 8 * ONE;
  localparam int PVTH = 30 * ONE;
  localparam int PDT  = ONE;
  localparam int K004 = 2621;      // round(0.04 * 2^16)
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -LMAX - 1;

  typedef struct {
    logic [NN-1:0] spk;
    int            due;
  } sweep_t;

  typedef struct {
    int addr;
    int v;
    int w;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  izhikevich_if #(.N(32), .NUM_NEURONS(NN), .ADDR_W(AW)) bus ();

  izhikevich_array #(.N(32), .Q(16), .NUM_NEURONS(NN), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  logic   rd_req = 1'b0;
  logic   rd_chk_p = 1'b0;
  sweep_t sweep_q[$];
  rd_t    rd_q[$];
  sweep_t mon_s;
  rd_t    mon_r;

  int mv[NN];
  int mw[NN];
  int mi[NN];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_chk_p <= rd_req;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h (cycle %0d)", name, act[31:0], exp[31:0], cyc);
    end
  endtask

  // ---------------- reference model: plain integer fixed-point ----------------
  function automatic int clampq(input longint s);
`ifdef IZH_SATURATE_EN
    if (s > LMAX) return int'(LMAX);
    if (s < LMIN) return int'(LMIN);
`endif
    return int'(s);
  endfunction

  function automatic int mulq(input int x, input int y);
    longint p;
    p = longint'(x) * longint'(y);
    return clampq(p >>> QS);
  endfunction

  function automatic int addq(input int x, input int y);
    return clampq(longint'(x) + longint'(y));
  endfunction

  function automatic int subq(input int x, input int y);
    return clampq(longint'(x) - longint'(y));
  endfunction

  task automatic model_sweep(output logic [NN-1:0] spk);
    int v, w, i, dv, dw, vn, wn;
    for (int k = 0; k < NN; k++) begin
      v  = mv[k];
      w  = mw[k];
      i  = mi[k];
      dv = addq(subq(addq(addq(mulq(K004, mulq(v, v)), mulq(5 * ONE, v)), 140 * ONE), w), i);
      dw = mulq(PA, subq(mulq(PB, v), w));
      vn = addq(v, mulq(dv, PDT));
      wn = addq(w, mulq(dw, PDT));
      if (vn >= PVTH) begin
        spk[k] = 1'b1;
        mv[k]  = PC;
        mw[k]  = addq(wn, PD);
      end else begin
        spk[k] = 1'b0;
        mv[k]  = vn;
        mw[k]  = wn;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.done) begin
      if (sweep_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_s = sweep_q.pop_front();
        check("spikes", longint'(bus.spikes), longint'(mon_s.spk));
        check("done_cycle", cyc, mon_s.due);
        check("busy_at_done", longint'(bus.busy), 0);
      end
    end
    if (rd_chk_p) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL readback_orphan actual=%08h required=none", bus.rd_voltage);
      end else begin
        mon_r = rd_q.pop_front();
        check($sformatf("rd_voltage[%0d]", mon_r.addr), longint'(bus.rd_voltage), longint'(mon_r.v));
        check($sformatf("rd_w[%0d]", mon_r.addr), longint'(bus.rd_w), longint'(mon_r.w));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int vi, input int wi);
    bus.v_init = vi;
    bus.w_init = wi;
    reset      = 1'b1;
    @(negedge clk);
    check("rst_spikes", longint'(bus.spikes), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_rd_voltage", longint'(bus.rd_voltage), 0);
    check("rst_rd_w", longint'(bus.rd_w), 0);
    reset = 1'b0;
    for (int k = 0; k < NN; k++) begin
      mv[k] = vi;
      mw[k] = wi;
      mi[k] = 0;
    end
    @(negedge clk);
  endtask

  task automatic write_cur(input int k, input int val);
    bus.cur_wr_en   = 1'b1;
    bus.cur_wr_addr = AW'(k);
    bus.cur_wr_data = val;
    @(negedge clk);
    bus.cur_wr_en = 1'b0;
    mi[k] = val;
  endtask

  task automatic issue_step(input bit expect_done);
    sweep_t e;
    bus.step = 1'b1;
    if (expect_done) begin
      model_sweep(e.spk);
      e.due = cyc + 3 * NN + 1;
      sweep_q.push_back(e);
    end
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sweep_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout actual=%0d required=0 pending sweeps", sweep_q.size());
      sweep_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic readback_all();
    rd_t r;
    for (int k = 0; k < NN; k++) begin
      bus.rd_addr = AW'(k);
      r.addr = k;
      r.v    = mv[k];
      r.w    = mw[k];
      rd_q.push_back(r);
      rd_req = 1'b1;
      @(negedge clk);
    end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a = PA; bus.b = PB; bus.c = PC; bus.d = PD; bus.v_th = PVTH; bus.dt = PDT;
    bus.v_init = 0; bus.w_init = 0;
    bus.cur_wr_en = 1'b0; bus.cur_wr_addr = '0; bus.cur_wr_data = 0;
    bus.step = 1'b0; bus.rd_addr = '0;
    reset = 1'b1;
    @(negedge clk);

    // Reset values: v = -65.0, w = -13.0 everywhere
    do_reset(-65 * ONE, -13 * ONE);
    readback_all();

    // All-zero state: every neuron spikes, v -> c, w -> d
    do_reset(0, 0);
    issue_step(1);
    check("busy_after_step", longint'(bus.busy), 1);
    wait_idle();
    readback_all();

    // dv = 0 equilibrium point for v, w relaxes toward b*v
    do_reset(0, 140 * ONE);
    issue_step(1);
    wait_idle();
    readback_all();

    // Current write during FETCH of neuron 3, plus an ignored step while busy
    do_reset(-65 * ONE, -13 * ONE);
    write_cur(3, 2 * ONE);
    issue_step(1);
    repeat (9) @(negedge clk);
    write_cur(3, 10 * ONE);
    repeat (3) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    wait_idle();
    readback_all();
    issue_step(1);
    wait_idle();
    readback_all();

    // Reset in cycle 5 of a sweep aborts it
    issue_step(0);
    repeat (4) @(negedge clk);
    do_reset(5 * ONE, -2 * ONE);
    readback_all();
    issue_step(1);
    wait_idle();
    readback_all();

    // Randomized currents and initial states
    for (int it = 0; it < 8; it++) begin
      if (it % 3 == 0)
        do_reset(int'($urandom_range(0, 200 * ONE)) - 100 * ONE,
                 int'($urandom_range(0, 40 * ONE)) - 20 * ONE);
      for (int j = 0; j < 3; j++) begin
        if (it == 5) write_cur(int'($urandom_range(0, NN - 1)), int'($urandom()));
        else         write_cur(int'($urandom_range(0, NN - 1)),
                               int'($urandom_range(0, 40 * ONE)) - 20 * ONE);
      end
      issue_step(1);
      wait_idle();
      readback_all();
    end

    // Large voltage: overflow behaviour (wrap or saturate per build)
    do_reset(30000 * ONE, 0);
    issue_step(1);
    wait_idle();
    readback_all();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
